fabric2_mdecode: RTL and testbench
==================================

FABRIC2_MDECODE -- requirements
Module: fabric2_mdecode

Interface
REQ-001 Parameter PORTNO_WIDTH, default 11; width of the port number presented to the fabric arbiter.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 i_MAddr  input  32  master OCP address.
REQ-005 i_MCmd  input  3  master OCP command (IDLE=0, WR=1, RD=2, others treated as IDLE).
REQ-006 i_SCmdAccept  input  1  command accept from the switched slave path.
REQ-007 i_SResp  input  2  response from the switched slave path (NULL=0, DVA=1, FAIL=2, ERR=3).
REQ-008 o_act  output  1  transaction start strobe to the arbiter.
REQ-009 o_done  output  1  transaction completion strobe to the arbiter.
REQ-010 o_portno  output  PORTNO_WIDTH  destination slave port number.
REQ-011 o_lcl_sel  output  1  master accept/response taken from local signals instead of the fabric.
REQ-012 o_lcl_SCmdAccept  output  1  locally generated command accept.
REQ-013 o_lcl_SResp  output  2  locally generated response.

Function
REQ-014 Decode: port = i_MAddr[31:28]; values 0..4 are mapped, 5..15 are unmapped; o_portno is the port zero-extended to PORTNO_WIDTH.
REQ-015 FSM states: IDLE, WAIT_ACC, WAIT_RESP, LCL_RESP.
REQ-016 IDLE: a valid command (WR or RD) to a mapped port asserts o_act combinationally in the same cycle, and o_portno shows the decoded port.
REQ-017 IDLE: o_portno is registered on the o_act cycle and held from that register in all other states.
REQ-018 IDLE with o_act and i_SCmdAccept=1: WR goes to IDLE with o_done=1 in the same cycle, and RD goes to WAIT_RESP.
REQ-019 IDLE with o_act and i_SCmdAccept=0: goes to WAIT_ACC.
REQ-020 WAIT_ACC: o_act=0; on i_SCmdAccept, WR goes to IDLE with o_done=1 in the same cycle, and RD goes to WAIT_RESP; otherwise stays.
REQ-021 WAIT_RESP: i_SResp!=NULL asserts o_done in the same cycle and goes to IDLE; i_SResp is ignored in all other states.
REQ-022 o_act is at most one cycle per transaction and never asserted outside IDLE; o_done is a one-cycle strobe.
REQ-023 Back-to-back: a new command present in the cycle after o_done is decoded normally (no bubble beyond the return to IDLE).
REQ-024 The command type (WR/RD) is captured on the o_act cycle and is used for completion; i_MCmd changes after o_act are ignored until IDLE.
REQ-025 o_lcl_sel, o_lcl_SCmdAccept and o_lcl_SResp are 0 except as defined in Configuration.

Reset
REQ-026 While nrst=0: state=IDLE, portno register=0, captured command=IDLE, local response register=NULL.
REQ-027 Reset values of the outputs are o_act=0, o_done=0, o_portno=0, o_lcl_sel=0, o_lcl_SCmdAccept=0, o_lcl_SResp=NULL.
REQ-028 Reset asserted mid-transaction abandons the transaction with no o_done; the first cycle after release is IDLE.

Configuration
REQ-029 Macro FABRIC2_MDECODE_DECERR_EN.
- Defined: a WR or RD to an unmapped port in IDLE produces no o_act, and drives o_lcl_sel=1 and o_lcl_SCmdAccept=1 in that cycle, then the FSM enters LCL_RESP.
- LCL_RESP lasts one cycle with o_lcl_sel=1; RD drives o_lcl_SResp=ERR, WR drives o_lcl_SResp=NULL; the FSM then returns to IDLE.
- LCL_RESP asserts no o_done.
- Undefined: unmapped ports are forced to port 4 and handled as mapped; o_lcl_* are constant 0 and LCL_RESP is unreachable.

Verification
REQ-030 RD to 0x2000_0000 with accept in the same cycle and DVA two cycles later -> o_act=1 and o_portno=2 in cycle 0; o_done=1 in cycle 2 only.
REQ-031 WR to 0x4000_0010 with accept delayed 3 cycles -> o_act in cycle 0 only; o_portno=4 held; o_done coincides with the accept cycle; FSM returns to IDLE.
REQ-032 Back-to-back RD port 1 then WR port 3 -> two o_act strobes; o_portno changes 1->3 only at the second o_act.
REQ-033 With FABRIC2_MDECODE_DECERR_EN defined, RD to 0x9000_0000 -> o_act=0; o_lcl_SCmdAccept=1 in cycle 0; o_lcl_SResp=ERR in cycle 1; no o_done. With the macro undefined, the same RD -> o_act=1 and o_portno=4.
REQ-034 nrst pulsed low while in WAIT_RESP -> outputs take their reset values immediately; no o_done; a new RD after release is decoded normally.
REQ-035 i_SResp=DVA in IDLE or WAIT_ACC with no transaction pending in WAIT_RESP -> no o_done and no state change.

Source files
------------

// File: rtl/fabric2_mdecode.sv
`default_nettype none
// ============================================================================
// Module      : fabric2_mdecode
// Description : OCP master-side address decoder for the fabric arbiter.
//               Decodes i_MAddr[31:28] into a slave port number, strobes the
//               arbiter on transaction start (o_act) and completion (o_done),
//               and tracks accept/response handshakes through a small FSM.
//               Optional feature macro: FABRIC2_MDECODE_DECERR_EN
//                 defined   -> unmapped ports are answered locally
//                              (accept + ERR for RD, NULL for WR)
//                 undefined -> unmapped ports are folded onto port 4
// Revision    : 1.0 - initial release
// ============================================================================
module fabric2_mdecode #(
    parameter int PORTNO_WIDTH = 11
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [31:0]             i_MAddr,
    input  logic [2:0]              i_MCmd,
    input  logic                    i_SCmdAccept,
    input  logic [1:0]              i_SResp,
    output logic                    o_act,
    output logic                    o_done,
    output logic [PORTNO_WIDTH-1:0] o_portno,
    output logic                    o_lcl_sel,
    output logic                    o_lcl_SCmdAccept,
    output logic [1:0]              o_lcl_SResp
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACC  = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_LCL_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] c_cmd_idle  = 3'd0;
    localparam logic [2:0] c_cmd_wr    = 3'd1;
    localparam logic [2:0] c_cmd_rd    = 3'd2;
    localparam logic [1:0] c_resp_null = 2'd0;
    localparam logic [1:0] c_resp_err  = 2'd3;
    localparam logic [3:0] c_last_port = 4'd4;

    state_t                  state_q, state_d;
    logic [PORTNO_WIDTH-1:0] portno_q, portno_d;
    logic [2:0]              cmd_q, cmd_d;

    logic [3:0] w_port;
    logic       w_mapped;
    logic       w_cmd_valid;
    logic [3:0] w_dec_port;
    logic       w_take;
    logic       w_unused_addr;

    // Only the top nibble of the address selects the port.
    assign w_unused_addr = ^i_MAddr[27:0];

    assign w_port      = i_MAddr[31:28];
    assign w_mapped    = (w_port <= c_last_port);
    assign w_cmd_valid = (i_MCmd == c_cmd_wr) || (i_MCmd == c_cmd_rd);

`ifdef FABRIC2_MDECODE_DECERR_EN
    logic [1:0] lcl_resp_q, lcl_resp_d;
    logic       w_decerr;

    // Unmapped targets are not forwarded; they are answered locally.
    assign w_dec_port = w_port;
    assign w_take     = w_cmd_valid && w_mapped;
    assign w_decerr   = w_cmd_valid && !w_mapped;
`else
    // Unmapped targets are folded onto the last mapped port.
    assign w_dec_port = w_mapped ? w_port : c_last_port;
    assign w_take     = w_cmd_valid;
`endif

    // Next-state, register updates and strobe outputs.
    always_comb begin
        state_d          = state_q;
        portno_d         = portno_q;
        cmd_d            = cmd_q;
        o_act            = 1'b0;
        o_done           = 1'b0;
        o_portno         = portno_q;
        o_lcl_sel        = 1'b0;
        o_lcl_SCmdAccept = 1'b0;
        o_lcl_SResp      = c_resp_null;
`ifdef FABRIC2_MDECODE_DECERR_EN
        lcl_resp_d       = lcl_resp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // nrst gating keeps the combinational strobes quiet while
                // reset is held, even if the master presents a command.
                if (nrst && w_take) begin
                    o_act    = 1'b1;
                    o_portno = PORTNO_WIDTH'(w_dec_port);
                    portno_d = PORTNO_WIDTH'(w_dec_port);
                    cmd_d    = i_MCmd;
                    if (i_SCmdAccept) begin
                        if (i_MCmd == c_cmd_wr) begin
                            o_done  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_RESP;
                        end
                    end else begin
                        state_d = ST_WAIT_ACC;
                    end
                end
`ifdef FABRIC2_MDECODE_DECERR_EN
                else if (nrst && w_decerr) begin
                    o_lcl_sel        = 1'b1;
                    o_lcl_SCmdAccept = 1'b1;
                    lcl_resp_d       = (i_MCmd == c_cmd_rd) ? c_resp_err
                                                            : c_resp_null;
                    state_d          = ST_LCL_RESP;
                end
`endif
            end
            ST_WAIT_ACC: begin
                // Completion type comes from the command captured at o_act.
                if (i_SCmdAccept) begin
                    if (cmd_q == c_cmd_wr) begin
                        o_done  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_RESP;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (i_SResp != c_resp_null) begin
                    o_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LCL_RESP: begin
`ifdef FABRIC2_MDECODE_DECERR_EN
                o_lcl_sel   = 1'b1;
                o_lcl_SResp = lcl_resp_q;
                lcl_resp_d  = c_resp_null;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-transaction registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            portno_q <= '0;
            cmd_q    <= c_cmd_idle;
        end else begin
            state_q  <= state_d;
            portno_q <= portno_d;
            cmd_q    <= cmd_d;
        end
    end

`ifdef FABRIC2_MDECODE_DECERR_EN
    // Local response held for the single LCL_RESP cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lcl_resp_q <= c_resp_null;
        end else begin
            lcl_resp_q <= lcl_resp_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fabric2_mdecode.sv
`default_nettype none
// ============================================================================
// Module      : tb_fabric2_mdecode
// Description : Directed self-checking bench for fabric2_mdecode. Inputs are
//               driven 1ns after the rising edge; outputs are sampled on the
//               falling edge as one packed vector
//               {act, done, portno, lcl_sel, lcl_acc, lcl_resp}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric2_mdecode;

    localparam int PW = 11;

    logic          clk = 1'b0;
    logic          nrst;
    logic [31:0]   maddr;
    logic [2:0]    mcmd;
    logic          acc;
    logic [1:0]    sresp;
    logic          o_act, o_done, o_lcl_sel, o_lcl_SCmdAccept;
    logic [PW-1:0] o_portno;
    logic [1:0]    o_lcl_SResp;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [PW+5:0] e;

    wire [PW+5:0] obs = {o_act, o_done, o_portno, o_lcl_sel,
                         o_lcl_SCmdAccept, o_lcl_SResp};

    fabric2_mdecode #(.PORTNO_WIDTH(PW)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .i_MAddr          (maddr),
        .i_MCmd           (mcmd),
        .i_SCmdAccept     (acc),
        .i_SResp          (sresp),
        .o_act            (o_act),
        .o_done           (o_done),
        .o_portno         (o_portno),
        .o_lcl_sel        (o_lcl_sel),
        .o_lcl_SCmdAccept (o_lcl_SCmdAccept),
        .o_lcl_SResp      (o_lcl_SResp)
    );

    always #5 clk = ~clk;

    // Expected-vector builder: act, done, port, lcl_sel, lcl_acc, lcl_resp.
    function automatic logic [PW+5:0] ev(input logic a, input logic d,
                                         input int p, input logic s,
                                         input logic c, input logic [1:0] r);
        return {a, d, PW'(p), s, c, r};
    endfunction

    // Advance one cycle and present new master/slave inputs.
    task automatic drive(input logic [2:0] c, input logic [31:0] a,
                         input logic ac, input logic [1:0] r);
        @(posedge clk);
        #1;
        mcmd = c; maddr = a; acc = ac; sresp = r;
    endtask

    task automatic test_reset;
        nrst = 1'b0; mcmd = 3'd2; maddr = 32'h2000_0000; acc = 1'b1; sresp = 2'd1;
        @(negedge clk); @(negedge clk);
        e = ev(0,0,0,0,0,0); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        nrst = 1'b1; mcmd = 3'd0; maddr = 32'h0; acc = 1'b0; sresp = 2'd0;
        e = ev(0,0,0,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
    endtask

    task automatic test_rd_accept;
        drive(3'd2, 32'h2000_0000, 1'b1, 2'd0);
        e = ev(1,0,2,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rd_c0 got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd0);
        e = ev(0,0,2,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rd_c1 got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,1,2,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rd_c2_done got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,0,2,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rd_c3_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_wr_delayed;
        drive(3'd1, 32'h4000_0010, 1'b0, 2'd0);
        e = ev(1,0,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL wr_c0 got=%h exp=%h", obs, e); end
        drive(3'd1, 32'h4000_0010, 1'b0, 2'd0);
        e = ev(0,0,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL wr_c1_wait got=%h exp=%h", obs, e); end
        // Command changes mid-transaction must not alter completion type.
        drive(3'd2, 32'h1000_0000, 1'b0, 2'd0);
        e = ev(0,0,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL wr_c2_cmdchg got=%h exp=%h", obs, e); end
        drive(3'd2, 32'h1000_0000, 1'b1, 2'd0);
        e = ev(0,1,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL wr_c3_accept got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,0,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL wr_c4_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_back_to_back;
        drive(3'd2, 32'h1000_0000, 1'b1, 2'd0);
        e = ev(1,0,1,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_rd_act got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h3000_0000, 1'b0, 2'd1);
        e = ev(0,1,1,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_rd_done got=%h exp=%h", obs, e); end
        drive(3'd1, 32'h3000_0000, 1'b1, 2'd0);
        e = ev(1,1,3,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_wr_act got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd0);
        e = ev(0,0,3,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_idle got=%h exp=%h", obs, e); end
    endtask

    task automatic test_unmapped;
`ifdef FABRIC2_MDECODE_DECERR_EN
        drive(3'd2, 32'h9000_0000, 1'b1, 2'd0);
        e = ev(0,0,3,1,1,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_rd_c0 got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,0,3,1,0,3); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_rd_err got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd0);
        e = ev(0,0,3,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_rd_end got=%h exp=%h", obs, e); end
        drive(3'd1, 32'hF000_0004, 1'b0, 2'd0);
        e = ev(0,0,3,1,1,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_wr_c0 got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd0);
        e = ev(0,0,3,1,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_wr_null got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd0);
        e = ev(0,0,3,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_wr_end got=%h exp=%h", obs, e); end
`else
        drive(3'd2, 32'h9000_0000, 1'b1, 2'd0);
        e = ev(1,0,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_rd_c0 got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,1,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_rd_done got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd0);
        e = ev(0,0,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_rd_end got=%h exp=%h", obs, e); end
        drive(3'd1, 32'hF000_0004, 1'b1, 2'd0);
        e = ev(1,1,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_wr_c0 got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,0,4,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL unm_wr_end got=%h exp=%h", obs, e); end
`endif
    endtask

    task automatic test_reset_mid;
        drive(3'd2, 32'h2000_0000, 1'b1, 2'd0);
        e = ev(1,0,2,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rmid_act got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd0);
        e = ev(0,0,2,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rmid_wait got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        nrst = 1'b0; mcmd = 3'd2; maddr = 32'h2000_0000; acc = 1'b1; sresp = 2'd1;
        #2;
        e = ev(0,0,0,0,0,0); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rmid_async got=%h exp=%h", obs, e); end
        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rmid_held got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        nrst = 1'b1; mcmd = 3'd2; maddr = 32'h1000_0000; acc = 1'b1; sresp = 2'd0;
        e = ev(1,0,1,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rmid_new_rd got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,1,1,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL rmid_new_done got=%h exp=%h", obs, e); end
    endtask

    task automatic test_stray_resp;
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,0,1,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL stray_idle got=%h exp=%h", obs, e); end
        drive(3'd3, 32'h1000_0000, 1'b1, 2'd0);
        e = ev(0,0,1,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL cmd3_ignored got=%h exp=%h", obs, e); end
        drive(3'd1, 32'h0000_0000, 1'b0, 2'd0);
        e = ev(1,0,0,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL stray_wr_act got=%h exp=%h", obs, e); end
        drive(3'd1, 32'h0000_0000, 1'b0, 2'd1);
        e = ev(0,0,0,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL stray_waitacc got=%h exp=%h", obs, e); end
        drive(3'd1, 32'h0000_0000, 1'b1, 2'd0);
        e = ev(0,1,0,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL stray_wr_done got=%h exp=%h", obs, e); end
        drive(3'd0, 32'h0, 1'b0, 2'd1);
        e = ev(0,0,0,0,0,0); @(negedge clk); n_cmp++;
        if (obs !== e) begin n_fail++; $display("FAIL stray_end got=%h exp=%h", obs, e); end
    endtask

    initial begin
        test_reset;
        test_rd_accept;
        test_wr_delayed;
        test_back_to_back;
        test_unmapped;
        test_reset_mid;
        test_stray_resp;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
